// File: rtl/cat_pkg.sv
// Shared types and constants for the cat sprite animation controller.
// Optional build macro used by the slice: CAT_ANIM_MIRROR_EN.
package cat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    THROW
  } cat_state_t;

  localparam int unsigned SPRITE_W = 64;
  localparam int unsigned SPRITE_H = 64;

  localparam logic [1:0] FRM_IDLE   = 2'd0;
  localparam logic [1:0] FRM_WALK_A = 2'd1;
  localparam logic [1:0] FRM_WALK_B = 2'd2;
  localparam logic [1:0] FRM_THROW  = 2'd3;

  localparam logic [11:0] TRANSPARENT_DEFAULT = 12'hF0F;

  // Alternate between the two walk frames.
  function automatic logic [1:0] next_walk_frame(input logic [1:0] frame);
    return (frame == FRM_WALK_A) ? FRM_WALK_B : FRM_WALK_A;
  endfunction

endpackage

// File: rtl/cat_addr_gen.sv
// Sprite ROM address generator: beam-relative offset, hit test and first pipeline stage.
// With CAT_ANIM_MIRROR_EN defined, a mirror input flips the column index.
module cat_addr_gen
  import cat_pkg::*;
(
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
`ifdef CAT_ANIM_MIRROR_EN
  input  logic        mirror,
`endif
  output logic [11:0] address,
  output logic        hit_d1
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [5:0]  col;
  logic        hit;

  // Unsigned wrap-around: beam left of / above the sprite yields a large offset, i.e. no hit.
  always_comb begin
    dx  = hcount - xpos;
    dy  = vcount - ypos;
    hit = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
    col = dx[5:0];
`ifdef CAT_ANIM_MIRROR_EN
    if (mirror) begin
      col = 6'd63 - dx[5:0];
    end
`endif
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      address <= 12'd0;
      hit_d1  <= 1'b0;
    end else begin
      address <= {dy[5:0], col};
      hit_d1  <= hit;
    end
  end

endmodule

// File: rtl/cat_anim_ctrl.sv
// Cat sprite animation sequencer and 3-stage ROM compositing pipeline.
// Define CAT_ANIM_MIRROR_EN to add the facing_left input for horizontal mirroring.
module cat_anim_ctrl
  import cat_pkg::*;
#(
  parameter int unsigned FRAME_DIV   = 8,
  parameter int unsigned THROW_HOLD  = 16,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        vsync_tick,
  input  logic        walk,
  input  logic        throw_req,
`ifdef CAT_ANIM_MIRROR_EN
  input  logic        facing_left,
`endif
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [11:0] rgb_in,
  input  logic [11:0] rgb0,
  input  logic [11:0] rgb1,
  input  logic [11:0] rgb2,
  input  logic [11:0] rgb3,
  output logic [11:0] address,
  output logic [1:0]  frame_sel,
  output logic        throw_busy,
  output logic [11:0] rgb_out
);

  cat_state_t  state_q, state_d;
  logic [1:0]  frame_sel_q, frame_sel_d;
  logic [15:0] walk_cnt_q, walk_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        pend_q, pend_d;
  logic        throw_go;

  logic        hit_d1, hit_d2;
  logic [1:0]  frame_d1, frame_d2;
  logic [11:0] rgb_d1, rgb_d2;
  logic [11:0] rom_word;
  logic [11:0] rgb_out_q, rgb_out_d;

  // ---------------------------------------------------------------------------
  // Animation state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_sel_q <= FRM_IDLE;
      walk_cnt_q  <= 16'd0;
      hold_cnt_q  <= 16'd0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_sel_q <= frame_sel_d;
      walk_cnt_q  <= walk_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_sel_d = frame_sel_q;
    walk_cnt_d  = walk_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pend_d      = pend_q;
    // A request arriving on the tick cycle itself is honoured directly.
    throw_go    = throw_req | pend_q;

    if (state_q == THROW) begin
      pend_d = 1'b0;
    end else if (vsync_tick) begin
      pend_d = 1'b0;
    end else if (throw_req) begin
      pend_d = 1'b1;
    end

    if (vsync_tick) begin
      unique case (state_q)
        IDLE: begin
          if (throw_go) begin
            state_d     = THROW;
            frame_sel_d = FRM_THROW;
            hold_cnt_d  = 16'd0;
            walk_cnt_d  = 16'd0;
          end else if (walk) begin
            state_d     = WALK;
            frame_sel_d = FRM_WALK_A;
            walk_cnt_d  = 16'd0;
          end
        end
        WALK: begin
          if (throw_go) begin
            state_d     = THROW;
            frame_sel_d = FRM_THROW;
            hold_cnt_d  = 16'd0;
            walk_cnt_d  = 16'd0;
          end else if (!walk) begin
            state_d     = IDLE;
            frame_sel_d = FRM_IDLE;
            walk_cnt_d  = 16'd0;
          end else if (walk_cnt_q + 16'd1 == 16'(FRAME_DIV)) begin
            frame_sel_d = next_walk_frame(frame_sel_q);
            walk_cnt_d  = 16'd0;
          end else begin
            walk_cnt_d = walk_cnt_q + 16'd1;
          end
        end
        THROW: begin
          if (hold_cnt_q + 16'd1 == 16'(THROW_HOLD)) begin
            hold_cnt_d = 16'd0;
            walk_cnt_d = 16'd0;
            if (walk) begin
              state_d     = WALK;
              frame_sel_d = FRM_WALK_A;
            end else begin
              state_d     = IDLE;
              frame_sel_d = FRM_IDLE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d     = IDLE;
          frame_sel_d = FRM_IDLE;
          walk_cnt_d  = 16'd0;
          hold_cnt_d  = 16'd0;
        end
      endcase
    end
  end

  assign frame_sel  = frame_sel_q;
  assign throw_busy = (state_q == THROW);

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
`ifdef CAT_ANIM_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      mirror_q <= 1'b0;
    end else if (vsync_tick) begin
      mirror_q <= facing_left;
    end
  end
`endif

  cat_addr_gen u_addr_gen (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .xpos     (xpos),
    .ypos     (ypos),
`ifdef CAT_ANIM_MIRROR_EN
    .mirror   (mirror_q),
`endif
    .address  (address),
    .hit_d1   (hit_d1)
  );

  // Frame index and background travel with the pixel so a mid-line frame change cannot tear.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      frame_d1  <= FRM_IDLE;
      frame_d2  <= FRM_IDLE;
      hit_d2    <= 1'b0;
      rgb_d1    <= 12'd0;
      rgb_d2    <= 12'd0;
      rgb_out_q <= 12'd0;
    end else begin
      frame_d1  <= frame_sel_q;
      frame_d2  <= frame_d1;
      hit_d2    <= hit_d1;
      rgb_d1    <= rgb_in;
      rgb_d2    <= rgb_d1;
      rgb_out_q <= rgb_out_d;
    end
  end

  always_comb begin
    rom_word = rgb0;
    unique case (frame_d2)
      FRM_IDLE:   rom_word = rgb0;
      FRM_WALK_A: rom_word = rgb1;
      FRM_WALK_B: rom_word = rgb2;
      FRM_THROW:  rom_word = rgb3;
      default:    rom_word = rgb0;
    endcase
    rgb_out_d = (hit_d2 && (rom_word != TRANSPARENT)) ? rom_word : rgb_d2;
  end

  assign rgb_out = rgb_out_q;

endmodule

// File: tb/tb_cat_anim_ctrl.sv
// Self-checking bench for cat_anim_ctrl: directed steps plus randomized stimulus
// checked against a behavioural model of the animation rules and sprite compositing.
module tb_cat_anim_ctrl;

  localparam int unsigned FrameDiv  = 8;
  localparam int unsigned ThrowHold = 16;
  localparam logic [11:0] Transp    = 12'hF0F;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic        vsync_tick;
  logic        walk;
  logic        throw_req;
  logic [10:0] hcount, vcount, xpos, ypos;
  logic [11:0] rgb_in;
  logic [11:0] rgb0, rgb1, rgb2, rgb3;
  logic [11:0] address;
  logic [1:0]  frame_sel;
  logic        throw_busy;
  logic [11:0] rgb_out;
`ifdef CAT_ANIM_MIRROR_EN
  logic        facing_left;
`endif

  always #5 clk60MHz = ~clk60MHz;

  cat_anim_ctrl #(
    .FRAME_DIV   (FrameDiv),
    .THROW_HOLD  (ThrowHold),
    .TRANSPARENT (Transp)
  ) dut (
    .clk60MHz    (clk60MHz),
    .rst         (rst),
    .vsync_tick  (vsync_tick),
    .walk        (walk),
    .throw_req   (throw_req),
`ifdef CAT_ANIM_MIRROR_EN
    .facing_left (facing_left),
`endif
    .hcount      (hcount),
    .vcount      (vcount),
    .xpos        (xpos),
    .ypos        (ypos),
    .rgb_in      (rgb_in),
    .rgb0        (rgb0),
    .rgb1        (rgb1),
    .rgb2        (rgb2),
    .rgb3        (rgb3),
    .address     (address),
    .frame_sel   (frame_sel),
    .throw_busy  (throw_busy),
    .rgb_out     (rgb_out)
  );

  // Sprite ROMs with one cycle of read latency.
  logic [11:0] rom [4][4096];

  always @(posedge clk60MHz) begin
    rgb0 <= rom[0][address];
    rgb1 <= rom[1][address];
    rgb2 <= rom[2][address];
    rgb3 <= rom[3][address];
  end

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the animation
  int m_frame;
  int m_held;
  int m_steps;
  bit m_throwing;
  bit m_walking;
  bit m_pending;
  bit m_mirror;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic model_reset();
    m_frame    = 0;
    m_held     = 0;
    m_steps    = 0;
    m_throwing = 0;
    m_walking  = 0;
    m_pending  = 0;
    m_mirror   = 0;
  endtask

  task automatic model_tick(input bit go);
    if (m_throwing) begin
      m_held++;
      if (m_held == ThrowHold) begin
        m_throwing = 0;
        m_walking  = walk;
        m_steps    = 0;
        m_frame    = walk ? 1 : 0;
      end
    end else if (go) begin
      m_throwing = 1;
      m_held     = 0;
      m_walking  = 0;
      m_frame    = 3;
    end else if (m_walking) begin
      if (!walk) begin
        m_walking = 0;
        m_frame   = 0;
      end else begin
        m_steps++;
        if (m_steps == FrameDiv) begin
          m_steps = 0;
          m_frame = (m_frame == 1) ? 2 : 1;
        end
      end
    end else if (walk) begin
      m_walking = 1;
      m_steps   = 0;
      m_frame   = 1;
    end
  endtask

  task automatic pulse_throw();
    throw_req = 1'b1;
    step();
    throw_req = 1'b0;
    if (!m_throwing) m_pending = 1;
  endtask

  task automatic tick(input string tag);
    bit go;
    vsync_tick = 1'b1;
    step();
    vsync_tick = 1'b0;
    go        = m_pending;
    m_pending = 0;
    model_tick(go);
`ifdef CAT_ANIM_MIRROR_EN
    m_mirror = facing_left;
`endif
    check({tag, ".frame_sel"}, {10'd0, frame_sel}, 12'(m_frame));
    check({tag, ".throw_busy"}, {11'd0, throw_busy}, {11'd0, m_throwing});
  endtask

  function automatic logic [11:0] model_addr(input logic [10:0] h, input logic [10:0] v,
                                             input logic [10:0] x, input logic [10:0] y);
    logic [10:0] dx, dy;
    logic [5:0]  c;
    dx = h - x;
    dy = v - y;
    c  = m_mirror ? 6'd63 - dx[5:0] : dx[5:0];
    return {dy[5:0], c};
  endfunction

  function automatic logic [11:0] model_pix(input logic [10:0] h, input logic [10:0] v,
                                            input logic [10:0] x, input logic [10:0] y,
                                            input logic [11:0] bg);
    logic [10:0] dx, dy;
    logic [11:0] w;
    dx = h - x;
    dy = v - y;
    w  = rom[m_frame][model_addr(h, v, x, y)];
    return ((dx < 64) && (dy < 64) && (w != Transp)) ? w : bg;
  endfunction

  // Hold one beam position for the full latency and check both pipeline ends.
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic [10:0] x, input logic [10:0] y, input logic [11:0] bg,
                     input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    hcount = h;
    vcount = v;
    xpos   = x;
    ypos   = y;
    rgb_in = bg;
    step();
    check({tag, ".address"}, address, exp_addr);
    step();
    step();
    check({tag, ".rgb_out"}, rgb_out, exp_rgb);
  endtask

  // Stream a new random pixel every cycle; outputs are checked against queued expectations.
  task automatic stream(input string tag, input int n);
    logic [11:0] q[$];
    logic [11:0] prev_addr;
    logic [10:0] off_h, off_v;
    bit          have_prev;
    have_prev = 0;
    prev_addr = 12'd0;
    for (int i = 0; i < n + 3; i++) begin
      if (have_prev) check({tag, ".address"}, address, prev_addr);
      if (q.size() == 3) check({tag, ".rgb_out"}, rgb_out, q.pop_front());
      xpos   = 11'($urandom_range(0, 2047));
      ypos   = 11'($urandom_range(0, 2047));
      off_h  = 11'($urandom_range(0, 80));
      off_v  = 11'($urandom_range(0, 80));
      hcount = xpos + off_h - 11'd8;
      vcount = ypos + off_v - 11'd8;
      rgb_in = 12'($urandom());
      if (i < n) begin
        q.push_back(model_pix(hcount, vcount, xpos, ypos, rgb_in));
        prev_addr = model_addr(hcount, vcount, xpos, ypos);
        have_prev = 1;
      end else begin
        have_prev = 0;
      end
      step();
    end
  endtask

  initial begin
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 4096; a++) begin
        rom[f][a] = ($urandom_range(0, 3) == 0) ? Transp : 12'($urandom());
      end
    end
    rst        = 1'b1;
    vsync_tick = 1'b0;
    walk       = 1'b0;
    throw_req  = 1'b0;
    hcount     = 11'd0;
    vcount     = 11'd0;
    xpos       = 11'd0;
    ypos       = 11'd0;
    rgb_in     = 12'hABC;
`ifdef CAT_ANIM_MIRROR_EN
    facing_left = 1'b0;
`endif
    model_reset();

    // Reset
    step();
    step();
    check("reset.rgb_out", rgb_out, 12'h000);
    check("reset.frame_sel", {10'd0, frame_sel}, 12'h000);
    check("reset.throw_busy", {11'd0, throw_busy}, 12'h000);
    check("reset.address", address, 12'h000);
    rst = 1'b0;

    // Hit, latency, transparency and wrap-around in the idle frame
    rom[0][0]       = 12'h123;
    rom[0][12'hFFF] = 12'h321;
    pix("hit_origin", 11'd100, 11'd50, 11'd100, 11'd50, 12'h456, 12'h000, 12'h123);
    pix("right_edge_out", 11'd164, 11'd50, 11'd100, 11'd50, 12'h9C3, 12'h000, 12'h9C3);
    pix("corner_in", 11'd163, 11'd113, 11'd100, 11'd50, 12'h111, 12'hFFF, 12'h321);
    pix("bottom_out", 11'd163, 11'd114, 11'd100, 11'd50, 12'h222, 12'h03F, 12'h222);
    pix("wrap_left", 11'd99, 11'd50, 11'd100, 11'd50, 12'h777, 12'h03F, 12'h777);
    rom[0][0] = Transp;
    pix("transparent", 11'd100, 11'd50, 11'd100, 11'd50, 12'h5A5, 12'h000, 12'h5A5);
    stream("stream_idle", 200);

    // Walk cycle
    walk = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      step();
      tick("walk");
      if (t == 1) check("walk.first", {10'd0, frame_sel}, 12'd1);
      if (t == 9) check("walk.second", {10'd0, frame_sel}, 12'd2);
    end
    walk = 1'b0;
    tick("walk_stop");
    check("walk_stop.idle", {10'd0, frame_sel}, 12'd0);

    // Walk again, then throw mid-frame
    walk = 1'b1;
    tick("walk2");
    stream("stream_walk", 150);
    step();
    pulse_throw();
    step();
    tick("throw_enter");
    check("throw_enter.busy", {11'd0, throw_busy}, 12'd1);
    pulse_throw();
    stream("stream_throw", 150);
    for (int t = 0; t < ThrowHold - 1; t++) begin
      step();
      tick("throw_hold");
    end
    check("throw_hold.frame", {10'd0, frame_sel}, 12'd3);
    step();
    tick("throw_exit");
    check("throw_exit.walk_a", {10'd0, frame_sel}, 12'd1);

    // Reset in the middle of a throw
    pulse_throw();
    tick("throw2_enter");
    for (int t = 0; t < 5; t++) tick("throw2_hold");
    rst = 1'b1;
    step();
    check("rst_throw.frame_sel", {10'd0, frame_sel}, 12'd0);
    check("rst_throw.throw_busy", {11'd0, throw_busy}, 12'd0);
    check("rst_throw.address", address, 12'h000);
    check("rst_throw.rgb_out", rgb_out, 12'h000);
    rst = 1'b0;
    model_reset();
    walk = 1'b0;
    tick("after_rst");

    // Randomized animation
    for (int t = 0; t < 80; t++) begin
      walk = ($urandom_range(0, 3) != 0);
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        if ($urandom_range(0, 9) == 0) pulse_throw();
        else step();
      end
      tick("rand_anim");
    end
    stream("stream_rand", 150);

`ifdef CAT_ANIM_MIRROR_EN
    facing_left = 1'b1;
    tick("mirror_on");
    pix("mirror_dx0", 11'd100, 11'd50, 11'd100, 11'd50, 12'h0F0, 12'h03F,
        model_pix(11'd100, 11'd50, 11'd100, 11'd50, 12'h0F0));
    stream("stream_mirror", 150);
    facing_left = 1'b0;
    tick("mirror_off");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cat_anim_ctrl.md
# cat_anim_ctrl

Animation sequencer and pixel-pipeline controller for the four-frame cat sprite ROM. Selects the active frame (idle, walk A, walk B, throw) from player commands, advancing only on frame boundaries. Generates the sprite ROM address from the current beam position and sprite origin. Composites the returned ROM pixel over the incoming background stream, with transparency. Sits between the timing/background stage and the next draw stage of the graphic interface.

## Interface

Parameters:
- FRAME_DIV, 8: vsync ticks per walk-frame step.
- THROW_HOLD, 16: vsync ticks the throw frame is held.
- TRANSPARENT, 12'hF0F: ROM colour treated as see-through.

Ports:
- clk60MHz  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- vsync_tick  in  1  one-cycle pulse at the start of each video frame.
- walk  in  1  level: cat is walking.
- throw_req  in  1  one-cycle pulse requesting a throw.
- hcount, vcount  in  11 each  current beam position.
- xpos, ypos  in  11 each  sprite top-left corner.
- rgb_in  in  12  background pixel.
- rgb0..rgb3  in  12 each  registered ROM outputs for frames 0..3 (1-cycle read latency).
- address  out  12  ROM address {dy[5:0], dx[5:0]}, fanned out to all four ROM ports.
- frame_sel  out  2  active frame index.
- throw_busy  out  1  high while in THROW.
- rgb_out  out  12  composited pixel.

## Operation

- State machine: IDLE, WALK, THROW. State and frame_sel update only in a cycle where vsync_tick=1.
- IDLE: frame_sel=0.
  - throw_req → THROW.
  - Otherwise walk=1 → WALK.
- WALK: a tick counter counts vsync ticks. At FRAME_DIV ticks, frame_sel toggles 1↔2 and the counter clears. Entry frame is 1.
  - throw_req → THROW.
  - Otherwise walk=0 → IDLE.
- THROW: frame_sel=3 and throw_busy=1. A hold counter counts vsync ticks. After THROW_HOLD ticks, exit to WALK if walk=1, else IDLE; counters clear on exit.
  - throw_req is ignored while in THROW and is not queued.
- throw_req latching: a throw_req pulse in any cycle is latched into a pending flag, consumed at the next vsync_tick. The flag is cleared if the block is already in THROW.
- Throw priority: throw_req and a walk change in the same frame → throw wins.
- Address generation: dx = hcount − xpos, dy = vcount − ypos, as 11-bit unsigned wrap-around subtraction.
  - hit = (dx < 64) && (dy < 64).
  - address = {dy[5:0], dx[5:0]}.
- Compositing: the ROM word is selected by the frame_sel delayed to match the pipeline.
  - rgb_out = rgb_in (delayed) if hit is delayed-false or the ROM word equals TRANSPARENT.
  - Otherwise rgb_out = ROM word.

## Timing

- Pipeline, with cycle 0 the cycle in which hcount/vcount/rgb_in are sampled:
  - Edge 1: address, hit_d1 and frame_d1 registered.
  - Edge 2: ROM data valid; hit_d2 and frame_d2 registered.
  - Edge 3: rgb_out registered.
  - Total latency 3 cycles. rgb_in is delayed 3 cycles internally to align.
- frame_sel changes one cycle after the vsync_tick edge. Because the pipeline frame index travels with the pixel, no frame tears mid-pixel.
- Reset values:
  - state=IDLE, frame_sel=0, throw_busy=0.
  - address=0, rgb_out=0.
  - All delay registers, counters and the pending flag cleared.
- Reset mid-THROW aborts the throw immediately; the next cycle is IDLE.
- xpos/ypos are sampled every cycle. Callers change them only during blanking.

## Configuration

- CAT_ANIM_MIRROR_EN defined:
  - Adds input `facing_left` (1 bit), sampled on vsync_tick only.
  - When latched high, the address uses dx' = 63 − dx[5:0], drawing the sprite horizontally mirrored. Latency is unchanged.
- Undefined: no port, and dx is used directly.

## Structure

- Shared package `cat_pkg` holds:
  - the state enum `cat_state_t` (IDLE, WALK, THROW);
  - SPRITE_W=64 and SPRITE_H=64;
  - frame index constants FRM_IDLE=0, FRM_WALK_A=1, FRM_WALK_B=2, FRM_THROW=3;
  - the TRANSPARENT default.
- One sub-module `cat_addr_gen` performs the dx/dy subtraction, the hit test, optional mirroring and the edge-1 register stage.
- The state machine, counters and compositing mux stay in the top.

## Test plan

- Reset: hold rst 2 cycles → rgb_out=0, frame_sel=0, throw_busy=0, address=0.
- Walk cycle: walk=1, FRAME_DIV=8, 40 vsync_ticks → frame_sel goes 1 at tick 1, then 2,1,2,1 every 8 ticks. walk=0 → 0 at the next tick.
- Throw:
  - throw_req mid-frame while walking → frame_sel=3 and throw_busy=1 after the next tick, held 16 ticks, then back to the walk frame 1.
  - A second throw_req during THROW has no effect.
- Hit/latency: xpos=100, ypos=50, hcount=100, vcount=50 → address=12'h000 at edge 1.
  - Non-transparent ROM word 12'h123 → rgb_out=12'h123 at edge 3.
  - hcount=164 → rgb_out=rgb_in delayed 3.
- Transparency and wrap: ROM word 12'hF0F inside the box → background passes. hcount=99, xpos=100 (dx wraps to 2047) → no hit.
- Reset mid-throw: assert rst at THROW hold count 5 → IDLE and frame_sel=0 the next cycle, pipeline zeroed. With CAT_ANIM_MIRROR_EN and facing_left=1, dx=0 gives address[5:0]=63.
